// File: rtl/cadr_pkg.sv
// rtl/cadr_pkg.sv - shared A-memory constants and spy-port state encoding
package cadr_pkg;

    localparam int AMEM_AW = 10;
    localparam int AMEM_DW = 32;

    localparam logic [AMEM_DW-1:0] AMEM_CLR_VALUE = 32'h0000_0000;

    typedef enum logic [2:0] {
        SPY_IDLE     = 3'd0,
        SPY_RD_ISSUE = 3'd1,
        SPY_RD_WAIT  = 3'd2,
        SPY_WR       = 3'd3,
        SPY_ACK      = 3'd4,
        SPY_CLEAR    = 3'd5
    } spy_state_t;

endpackage

// File: rtl/amem_spy_port.sv
// rtl/amem_spy_port.sv - host/debug access and bulk-clear engine for the A memory
module amem_spy_port
    import cadr_pkg::*;
#(
    parameter int AW = AMEM_AW,
    parameter int DW = AMEM_DW,
    parameter logic [DW-1:0] CLR_VALUE = AMEM_CLR_VALUE
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          halted,
    input  logic          spy_req,
    input  logic          spy_wr,
    input  logic [AW-1:0] spy_adr,
    input  logic [DW-1:0] spy_wdata,
    output logic          spy_ack,
    output logic [DW-1:0] spy_rdata,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic [AW-1:0] aadr_o,
    output logic          arp_o,
    output logic          awp_o,
    output logic [DW-1:0] l_o,
    input  logic [DW-1:0] amem
);

    // Counter is one bit wider than the address so the sweep ends on the
    // carry out of the last address instead of wrapping back to zero.
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    spy_state_t    state, state_n;
    logic [AW:0]   cnt, cnt_n;
    logic          ack_n;
    logic          busy_n;
    logic          arp_n;
    logic          awp_n;
    logic [AW-1:0] adr_n;
    logic [DW-1:0] l_n;
    logic [DW-1:0] rdata_n;

    // Next-state and next-output decode; every output is registered below.
    // The host address/data are captured straight into aadr_o/l_o at
    // acceptance, so those registers double as the request latch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ack_n   = 1'b0;
        busy_n  = clr_busy;
        arp_n   = 1'b0;
        awp_n   = 1'b0;
        adr_n   = aadr_o;
        l_n     = l_o;
        rdata_n = spy_rdata;

        case (state)
            SPY_IDLE: begin
                if (clr_start) begin
                    // Clear beats a simultaneous host request; the request
                    // stays pending on spy_req and is taken after the sweep.
                    state_n = SPY_CLEAR;
                    busy_n  = 1'b1;
                    adr_n   = '0;
                    cnt_n   = '0;
                    if (halted) begin
                        awp_n = 1'b1;
                        l_n   = CLR_VALUE;
                        cnt_n = CNT_ONE;
                    end
                end else if (halted && spy_req) begin
                    adr_n = spy_adr;
                    if (spy_wr) begin
                        state_n = SPY_WR;
                        awp_n   = 1'b1;
                        l_n     = spy_wdata;
                    end else begin
                        state_n = SPY_RD_ISSUE;
                        arp_n   = 1'b1;
                    end
                end
            end

            SPY_WR: begin
                state_n = SPY_ACK;
            end

            SPY_RD_ISSUE: begin
                state_n = SPY_RD_WAIT;
            end

            SPY_RD_WAIT: begin
                // RAM output is valid one clock after the read strobe.
                rdata_n = amem;
                state_n = SPY_ACK;
            end

            SPY_ACK: begin
                if (spy_req) begin
                    ack_n = 1'b1;
                end else begin
                    state_n = SPY_IDLE;
                end
            end

            SPY_CLEAR: begin
                if (cnt[AW]) begin
                    // Last address was written on the previous cycle.
                    state_n = SPY_IDLE;
                    busy_n  = 1'b0;
                end else begin
                    // Address tracks the counter even while paused so the
                    // sweep resumes exactly where it stopped.
                    adr_n = cnt[AW-1:0];
                    if (halted) begin
                        awp_n = 1'b1;
                        l_n   = CLR_VALUE;
                        cnt_n = cnt + CNT_ONE;
                    end
                end
            end

            default: begin
                state_n = SPY_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SPY_IDLE;
            cnt       <= '0;
            spy_ack   <= 1'b0;
            spy_rdata <= '0;
            clr_busy  <= 1'b0;
            aadr_o    <= '0;
            arp_o     <= 1'b0;
            awp_o     <= 1'b0;
            l_o       <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            spy_ack   <= ack_n;
            spy_rdata <= rdata_n;
            clr_busy  <= busy_n;
            aadr_o    <= adr_n;
            arp_o     <= arp_n;
            awp_o     <= awp_n;
            l_o       <= l_n;
        end
    end

endmodule

// File: tb/tb_amem_spy_port.sv
// tb/tb_amem_spy_port.sv - directed self-checking bench for amem_spy_port
module tb_amem_spy_port;

    logic        clk;
    logic        reset;
    logic        halted;
    logic        spy_req;
    logic        spy_wr;
    logic [9:0]  spy_adr;
    logic [31:0] spy_wdata;
    logic        spy_ack;
    logic [31:0] spy_rdata;
    logic        clr_start;
    logic        clr_busy;
    logic [9:0]  aadr_o;
    logic        arp_o;
    logic        awp_o;
    logic [31:0] l_o;
    logic [31:0] amem;

    int passed = 0;
    int total  = 0;
    int both_hi = 0;

    logic [31:0] mem [1024];

    amem_spy_port dut (
        .clk       (clk),
        .reset     (reset),
        .halted    (halted),
        .spy_req   (spy_req),
        .spy_wr    (spy_wr),
        .spy_adr   (spy_adr),
        .spy_wdata (spy_wdata),
        .spy_ack   (spy_ack),
        .spy_rdata (spy_rdata),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .aadr_o    (aadr_o),
        .arp_o     (arp_o),
        .awp_o     (awp_o),
        .l_o       (l_o),
        .amem      (amem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered 1Kx32 RAM seen by the engine
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        amem = 32'h0;
    end

    always @(posedge clk) begin
        if (awp_o) mem[aadr_o] <= l_o;
        if (arp_o) amem <= mem[aadr_o];
    end

    always @(negedge clk) begin
        if (awp_o && arp_o) both_hi++;
    end

    // Raise a request at the current negedge and wait for spy_ack.
    task automatic access(input logic wr, input logic [9:0] adr, input logic [31:0] d,
                          output int lat, output int awps, output int arps,
                          output logic [9:0] sadr, output logic [31:0] sdat);
        spy_req   = 1'b1;
        spy_wr    = wr;
        spy_adr   = adr;
        spy_wdata = d;
        lat  = -1;
        awps = 0;
        arps = 0;
        sadr = '0;
        sdat = '0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (awp_o) begin awps++; sadr = aadr_o; sdat = l_o; end
            if (arp_o) begin arps++; sadr = aadr_o; end
            if (spy_ack) begin lat = i - 1; break; end
        end
    endtask

    // Hold spy_req for some cycles past the ack, then drop it.
    task automatic release_req(input int hold, output int strobes, output int ack_lows,
                               output logic ack_after);
        strobes  = 0;
        ack_lows = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (awp_o || arp_o) strobes++;
            if (!spy_ack) ack_lows++;
        end
        spy_req = 1'b0;
        @(negedge clk);
        ack_after = spy_ack;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (spy_ack !== 1'b0) $display("FAIL rst_ack: got %b want 0", spy_ack); else passed++;
        total++; if (spy_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", spy_rdata); else passed++;
        total++; if (clr_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", clr_busy); else passed++;
        total++; if ({arp_o, awp_o} !== 2'b00) $display("FAIL rst_strobes: got %b want 00", {arp_o, awp_o}); else passed++;
        total++; if (aadr_o !== 10'h0) $display("FAIL rst_aadr: got %h want 0", aadr_o); else passed++;
        total++; if (l_o !== 32'h0) $display("FAIL rst_l: got %h want 0", l_o); else passed++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read;
        int lat, aw, ar, st, al;
        logic [9:0] sa;
        logic [31:0] sd;
        logic aa;
        access(1'b1, 10'h123, 32'hDEADBEEF, lat, aw, ar, sa, sd);
        total++; if (lat !== 2) $display("FAIL wr_lat: got %0d want 2", lat); else passed++;
        total++; if (aw !== 1 || ar !== 0) $display("FAIL wr_pulses: got awp=%0d arp=%0d want 1/0", aw, ar); else passed++;
        total++; if (sa !== 10'h123 || sd !== 32'hDEADBEEF) $display("FAIL wr_bus: got %h/%h want 123/deadbeef", sa, sd); else passed++;
        release_req(0, st, al, aa);
        access(1'b0, 10'h123, 32'h0, lat, aw, ar, sa, sd);
        total++; if (lat !== 3) $display("FAIL rd_lat: got %0d want 3", lat); else passed++;
        total++; if (ar !== 1 || aw !== 0 || sa !== 10'h123) $display("FAIL rd_pulses: got arp=%0d awp=%0d adr=%h want 1/0/123", ar, aw, sa); else passed++;
        total++; if (spy_rdata !== 32'hDEADBEEF) $display("FAIL rd_data: got %h want deadbeef", spy_rdata); else passed++;
        release_req(0, st, al, aa);
        total++; if (spy_rdata !== 32'hDEADBEEF) $display("FAIL rd_hold: got %h want deadbeef", spy_rdata); else passed++;
        // second pattern at the top address
        access(1'b1, 10'h3FF, 32'h1234_5678, lat, aw, ar, sa, sd);
        release_req(0, st, al, aa);
        access(1'b0, 10'h3FF, 32'h0, lat, aw, ar, sa, sd);
        total++; if (spy_rdata !== 32'h1234_5678) $display("FAIL rd_top: got %h want 12345678", spy_rdata); else passed++;
        release_req(0, st, al, aa);
    endtask

    task automatic test_handshake;
        int lat, aw, ar, st, al;
        logic [9:0] sa;
        logic [31:0] sd;
        logic aa;
        access(1'b1, 10'h040, 32'hA5A5_0F0F, lat, aw, ar, sa, sd);
        release_req(5, st, al, aa);
        total++; if (st !== 0) $display("FAIL hs_extra_access: got %0d strobes want 0", st); else passed++;
        total++; if (al !== 0) $display("FAIL hs_ack_hold: got %0d low cycles want 0", al); else passed++;
        total++; if (aa !== 1'b0) $display("FAIL hs_ack_drop: got %b want 0", aa); else passed++;
    endtask

    task automatic test_halted_gating;
        int lat, aw, ar, st, al, bad;
        logic [9:0] sa;
        logic [31:0] sd;
        logic aa;
        halted    = 1'b0;
        spy_req   = 1'b1;
        spy_wr    = 1'b1;
        spy_adr   = 10'h02A;
        spy_wdata = 32'h0BAD_F00D;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awp_o || arp_o || spy_ack) bad++;
        end
        total++; if (bad !== 0) $display("FAIL gate_quiet: got %0d active cycles want 0", bad); else passed++;
        halted = 1'b1;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (spy_ack) begin lat = i - 1; break; end
        end
        total++; if (lat !== 2) $display("FAIL gate_lat: got %0d want 2", lat); else passed++;
        release_req(0, st, al, aa);
        access(1'b0, 10'h02A, 32'h0, lat, aw, ar, sa, sd);
        total++; if (spy_rdata !== 32'h0BAD_F00D) $display("FAIL gate_data: got %h want 0badf00d", spy_rdata); else passed++;
        release_req(0, st, al, aa);
    endtask

    task automatic test_clear;
        int lat, aw, ar, st, al, busy, awps;
        logic [9:0] sa;
        logic [31:0] sd;
        logic aa;
        logic [9:0] adrs [3];
        adrs[0] = 10'd0; adrs[1] = 10'd511; adrs[2] = 10'd1023;
        for (int k = 0; k < 3; k++) begin
            access(1'b1, adrs[k], 32'h5A5A_5A5A, lat, aw, ar, sa, sd);
            release_req(0, st, al, aa);
        end
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        busy = 0;
        awps = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!clr_busy) break;
            busy++;
            if (awp_o) awps++;
            @(negedge clk);
        end
        total++; if (busy !== 1024) $display("FAIL clr_busy_len: got %0d want 1024", busy); else passed++;
        total++; if (awps !== 1024) $display("FAIL clr_writes: got %0d want 1024", awps); else passed++;
        for (int k = 0; k < 3; k++) begin
            access(1'b0, adrs[k], 32'h0, lat, aw, ar, sa, sd);
            total++; if (spy_rdata !== 32'h0) $display("FAIL clr_read%0d: got %h want 0", k, spy_rdata); else passed++;
            release_req(0, st, al, aa);
        end
    endtask

    task automatic test_clear_collision;
        int lat, aw, ar, st, al, busy, awps, pause, bad_pause, bad_host, resumed;
        logic [9:0] sa;
        logic [31:0] sd;
        logic [9:0] resume_adr;
        logic aa;
        clr_start = 1'b1;
        spy_req   = 1'b1;
        spy_wr    = 1'b1;
        spy_adr   = 10'h005;
        spy_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        clr_start = 1'b0;
        busy = 0; awps = 0; pause = -1; bad_pause = 0; bad_host = 0; resumed = 0;
        resume_adr = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!clr_busy) break;
            busy++;
            if (awp_o) awps++;
            if (spy_ack || arp_o) bad_host++;
            if (pause == 0 && resumed == 0 && awp_o) begin resume_adr = aadr_o; resumed = 1; end
            if (pause > 0 && (awp_o || aadr_o !== 10'd300)) bad_pause++;
            if (pause == -1 && awp_o && aadr_o == 10'd299) begin
                halted = 1'b0;
                pause  = 10;
            end else if (pause > 0) begin
                pause--;
                if (pause == 0) halted = 1'b1;
            end
            @(negedge clk);
        end
        halted = 1'b1;
        total++; if (busy !== 1034) $display("FAIL col_busy_len: got %0d want 1034", busy); else passed++;
        total++; if (awps !== 1024) $display("FAIL col_writes: got %0d want 1024", awps); else passed++;
        total++; if (bad_pause !== 0) $display("FAIL col_pause_hold: got %0d bad cycles want 0", bad_pause); else passed++;
        total++; if (resume_adr !== 10'd300) $display("FAIL col_resume_adr: got %0d want 300", resume_adr); else passed++;
        total++; if (bad_host !== 0) $display("FAIL col_host_early: got %0d cycles want 0", bad_host); else passed++;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (spy_ack) begin lat = i; break; end
        end
        total++; if (lat < 0) $display("FAIL col_host_ack: got timeout want ack"); else passed++;
        release_req(0, st, al, aa);
        access(1'b0, 10'd300, 32'h0, lat, aw, ar, sa, sd);
        total++; if (spy_rdata !== 32'h0) $display("FAIL col_read300: got %h want 0", spy_rdata); else passed++;
        release_req(0, st, al, aa);
        access(1'b0, 10'h005, 32'h0, lat, aw, ar, sa, sd);
        total++; if (spy_rdata !== 32'hCAFE_F00D) $display("FAIL col_read5: got %h want cafef00d", spy_rdata); else passed++;
        release_req(0, st, al, aa);
    endtask

    task automatic test_reset_mid_read;
        int lat, aw, ar, st, al, acks;
        logic [9:0] sa;
        logic [31:0] sd;
        logic aa;
        spy_req = 1'b1;
        spy_wr  = 1'b0;
        spy_adr = 10'h005;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++; if (spy_rdata !== 32'h0) $display("FAIL mid_rdata: got %h want 0", spy_rdata); else passed++;
        total++; if ({spy_ack, arp_o, awp_o, clr_busy} !== 4'b0) $display("FAIL mid_ctrl: got %b want 0000", {spy_ack, arp_o, awp_o, clr_busy}); else passed++;
        total++; if (aadr_o !== 10'h0 || l_o !== 32'h0) $display("FAIL mid_bus: got %h/%h want 0/0", aadr_o, l_o); else passed++;
        @(negedge clk);
        spy_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (spy_ack) acks++;
        end
        total++; if (acks !== 0) $display("FAIL mid_no_ack: got %0d ack cycles want 0", acks); else passed++;
        access(1'b0, 10'h005, 32'h0, lat, aw, ar, sa, sd);
        total++; if (lat !== 3 || spy_rdata !== 32'hCAFE_F00D) $display("FAIL mid_reissue: got lat=%0d data=%h want 3/cafef00d", lat, spy_rdata); else passed++;
        release_req(0, st, al, aa);
    endtask

    initial begin
        reset     = 1'b1;
        halted    = 1'b1;
        spy_req   = 1'b0;
        spy_wr    = 1'b0;
        spy_adr   = '0;
        spy_wdata = '0;
        clr_start = 1'b0;
        test_reset();
        test_write_read();
        test_handshake();
        test_halted_gating();
        test_clear();
        test_clear_collision();
        test_reset_mid_read();
        total++; if (both_hi !== 0) $display("FAIL strobe_overlap: got %0d cycles want 0", both_hi); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
